dcache_wb_bank: RTL and testbench



---
 rtl/dcache_pkg.sv | 25 ++
 rtl/dcache_lru.sv | 46 ++++
 rtl/dcache_wb_bank.sv | 246 ++++++++++++++++++++++++
 tb/tb_dcache_wb_bank.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared types and address-field width helpers for the write-back data cache bank.
// Block size and set count are expected to be at least 2 so every field is non-empty.
package dcache_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_WRITEBACK,
        ST_REFILL,
        ST_RESPOND
    } state_t;

    function automatic int offset_width(input int block_size);
        return $clog2(block_size);
    endfunction

    function automatic int index_width(input int num_sets);
        return $clog2(num_sets);
    endfunction

    function automatic int tag_width(input int addr_bits, input int num_sets, input int block_size);
        return addr_bits - $clog2(num_sets) - $clog2(block_size);
    endfunction

endpackage

// File: rtl/dcache_lru.sv
// True-LRU age vector for one cache set: ages form a permutation, 0 = most recent.
// The victim is the lowest invalid way, otherwise the oldest way.
module dcache_lru #(
    parameter int NUM_WAYS = 4
)(
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        touch,
    input  logic [$clog2(NUM_WAYS)-1:0] touch_way,
    input  logic [NUM_WAYS-1:0]         valid_mask,
    output logic [$clog2(NUM_WAYS)-1:0] victim
);

    localparam int WAY_W = $clog2(NUM_WAYS);

    logic [NUM_WAYS-1:0][WAY_W-1:0] age_reg;
    logic [WAY_W-1:0]               touched_age;

    assign touched_age = age_reg[touch_way];

    for (genvar gi = 0; gi < NUM_WAYS; gi++) begin : g_age
        always_ff @(posedge clk) begin
            if (reset) begin
                age_reg[gi] <= WAY_W'(gi);
            end else if (touch) begin
                if (touch_way == WAY_W'(gi)) begin
                    age_reg[gi] <= '0;
                end else if (age_reg[gi] < touched_age) begin
                    age_reg[gi] <= age_reg[gi] + 1'b1;
                end
            end
        end
    end

    // Oldest way first, then let the lowest invalid way override it.
    always_comb begin
        victim = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (age_reg[w] == WAY_W'(NUM_WAYS - 1)) victim = WAY_W'(w);
        end
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (!valid_mask[w]) victim = WAY_W'(w);
        end
    end

endmodule

// File: rtl/dcache_wb_bank.sv
// Blocking set-associative write-back/write-allocate cache bank shared by several
// consumer channels through a round-robin arbiter, with burst refill and eviction.
module dcache_wb_bank
    import dcache_pkg::*;
#(
    parameter int ADDR_BITS        = 8,
    parameter int DATA_BITS        = 8,
    parameter int NUM_CONSUMERS    = 8,
    parameter int NUM_SETS         = 4,
    parameter int NUM_WAYS         = 4,
    parameter int CACHE_BLOCK_SIZE = 2
)(
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic [NUM_CONSUMERS-1:0]                 consumer_read_valid,
    input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]  consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]                 consumer_read_ready,
    output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]  consumer_read_data,
    input  logic [NUM_CONSUMERS-1:0]                 consumer_write_valid,
    input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]  consumer_write_address,
    input  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]  consumer_write_data,
    output logic [NUM_CONSUMERS-1:0]                 consumer_write_ready,
    output logic                                     mem_read_valid,
    output logic [ADDR_BITS-1:0]                     mem_read_address,
    input  logic                                     mem_read_ready,
    input  logic [DATA_BITS-1:0]                     mem_read_data,
    output logic                                     mem_write_valid,
    output logic [ADDR_BITS-1:0]                     mem_write_address,
    output logic [DATA_BITS-1:0]                     mem_write_data,
    input  logic                                     mem_write_ready
);

    localparam int OFF_W = offset_width(CACHE_BLOCK_SIZE);
    localparam int IDX_W = index_width(NUM_SETS);
    localparam int TAG_W = tag_width(ADDR_BITS, NUM_SETS, CACHE_BLOCK_SIZE);
    localparam int WAY_W = $clog2(NUM_WAYS);
    localparam int CON_W = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;
    localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(CACHE_BLOCK_SIZE - 1);

    typedef struct packed {
        logic                                       valid;
        logic                                       dirty;
        logic [TAG_W-1:0]                           tag;
        logic [CACHE_BLOCK_SIZE-1:0][DATA_BITS-1:0] words;
    } line_t;

    line_t lines_reg [NUM_SETS][NUM_WAYS];

    state_t                                  state_reg;
    logic [CON_W-1:0]                        rr_ptr_reg;
    logic [CON_W-1:0]                        grant_reg;
    logic                                    req_write_reg;
    logic [ADDR_BITS-1:0]                    req_addr_reg;
    logic [DATA_BITS-1:0]                    req_data_reg;
    logic [WAY_W-1:0]                        way_reg;
    logic [OFF_W-1:0]                        beat_reg;
    logic [NUM_CONSUMERS-1:0]                read_ready_reg;
    logic [NUM_CONSUMERS-1:0]                write_ready_reg;
    logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] read_data_reg;
    logic                                    mem_read_valid_reg;
    logic [ADDR_BITS-1:0]                    mem_read_address_reg;
    logic                                    mem_write_valid_reg;
    logic [ADDR_BITS-1:0]                    mem_write_address_reg;
    logic [DATA_BITS-1:0]                    mem_write_data_reg;

    logic [TAG_W-1:0]               req_tag;
    logic [IDX_W-1:0]               req_idx;
    logic [OFF_W-1:0]               req_off;
    logic [NUM_WAYS-1:0]            hit_vec;
    logic                           hit;
    logic [WAY_W-1:0]               hit_way;
    logic [NUM_SETS-1:0][WAY_W-1:0] victim_all;
    logic [WAY_W-1:0]               victim_way;
    line_t                          victim_line;
    line_t                          cur_line;
    logic                           arb_found;
    logic                           arb_write;
    logic [CON_W-1:0]               arb_sel;
    logic [CON_W-1:0]               arb_next;

    assign req_tag     = req_addr_reg[ADDR_BITS-1 -: TAG_W];
    assign req_idx     = req_addr_reg[OFF_W +: IDX_W];
    assign req_off     = req_addr_reg[OFF_W-1:0];
    assign victim_way  = victim_all[req_idx];
    assign victim_line = lines_reg[req_idx][victim_way];
    assign cur_line    = lines_reg[req_idx][way_reg];

    for (genvar gi = 0; gi < NUM_WAYS; gi++) begin : g_hit
        assign hit_vec[gi] = lines_reg[req_idx][gi].valid && (lines_reg[req_idx][gi].tag == req_tag);
    end

    assign hit = |hit_vec;

    always_comb begin
        hit_way = '0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (hit_vec[w]) hit_way = WAY_W'(w);
        end
    end

    for (genvar gi = 0; gi < NUM_SETS; gi++) begin : g_set
        logic [NUM_WAYS-1:0] valid_mask;
        logic                touch;

        always_comb begin
            valid_mask = '0;
            for (int w = 0; w < NUM_WAYS; w++) valid_mask[w] = lines_reg[gi][w].valid;
        end

        // Every completed access refreshes recency, including the one that caused a refill.
        assign touch = (state_reg == ST_RESPOND) && (req_idx == IDX_W'(gi));

        dcache_lru #(
            .NUM_WAYS(NUM_WAYS)
        ) u_lru (
            .clk        (clk),
            .reset      (reset),
            .touch      (touch),
            .touch_way  (way_reg),
            .valid_mask (valid_mask),
            .victim     (victim_all[gi])
        );
    end

    // Round-robin scan from the pointer; a consumer's read wins over its own write.
    always_comb begin
        int cand;
        arb_found = 1'b0;
        arb_write = 1'b0;
        arb_sel   = '0;
        cand      = 0;
        for (int k = 0; k < NUM_CONSUMERS; k++) begin
            cand = int'(rr_ptr_reg) + k;
            if (cand >= NUM_CONSUMERS) cand = cand - NUM_CONSUMERS;
            if (!arb_found && (consumer_read_valid[cand] || consumer_write_valid[cand])) begin
                arb_found = 1'b1;
                arb_sel   = CON_W'(cand);
                arb_write = !consumer_read_valid[cand];
            end
        end
    end

    assign arb_next = (arb_sel == CON_W'(NUM_CONSUMERS - 1)) ? '0 : arb_sel + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg             <= ST_IDLE;
            rr_ptr_reg            <= '0;
            grant_reg             <= '0;
            req_write_reg         <= 1'b0;
            req_addr_reg          <= '0;
            req_data_reg          <= '0;
            way_reg               <= '0;
            beat_reg              <= '0;
            read_ready_reg        <= '0;
            write_ready_reg       <= '0;
            read_data_reg         <= '0;
            mem_read_valid_reg    <= 1'b0;
            mem_read_address_reg  <= '0;
            mem_write_valid_reg   <= 1'b0;
            mem_write_address_reg <= '0;
            mem_write_data_reg    <= '0;
            for (int s = 0; s < NUM_SETS; s++) begin
                for (int w = 0; w < NUM_WAYS; w++) begin
                    lines_reg[s][w].valid <= 1'b0;
                    lines_reg[s][w].dirty <= 1'b0;
                end
            end
        end else begin
            read_ready_reg  <= '0;
            write_ready_reg <= '0;
            case (state_reg)
                ST_IDLE: begin
                    if (arb_found) begin
                        grant_reg     <= arb_sel;
                        req_write_reg <= arb_write;
                        req_addr_reg  <= arb_write ? consumer_write_address[arb_sel]
                                                   : consumer_read_address[arb_sel];
                        req_data_reg  <= consumer_write_data[arb_sel];
                        rr_ptr_reg    <= arb_next;
                        state_reg     <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    if (hit) begin
                        way_reg   <= hit_way;
                        state_reg <= ST_RESPOND;
                    end else begin
                        way_reg   <= victim_way;
                        beat_reg  <= '0;
                        state_reg <= (victim_line.valid && victim_line.dirty) ? ST_WRITEBACK : ST_REFILL;
                    end
                end
                ST_WRITEBACK: begin
                    if (!mem_write_valid_reg) begin
                        mem_write_valid_reg   <= 1'b1;
                        mem_write_address_reg <= {cur_line.tag, req_idx, beat_reg};
                        mem_write_data_reg    <= cur_line.words[beat_reg];
                    end else if (mem_write_ready) begin
                        mem_write_valid_reg <= 1'b0;
                        beat_reg            <= beat_reg + 1'b1;
                        if (beat_reg == LAST_BEAT) state_reg <= ST_REFILL;
                    end
                end
                ST_REFILL: begin
                    if (!mem_read_valid_reg) begin
                        mem_read_valid_reg   <= 1'b1;
                        mem_read_address_reg <= {req_tag, req_idx, beat_reg};
                    end else if (mem_read_ready) begin
                        mem_read_valid_reg                          <= 1'b0;
                        lines_reg[req_idx][way_reg].words[beat_reg] <= mem_read_data;
                        beat_reg                                    <= beat_reg + 1'b1;
                        if (beat_reg == LAST_BEAT) begin
                            lines_reg[req_idx][way_reg].valid <= 1'b1;
                            lines_reg[req_idx][way_reg].dirty <= 1'b0;
                            lines_reg[req_idx][way_reg].tag   <= req_tag;
                            state_reg                         <= ST_RESPOND;
                        end
                    end
                end
                ST_RESPOND: begin
                    if (req_write_reg) begin
                        lines_reg[req_idx][way_reg].words[req_off] <= req_data_reg;
                        lines_reg[req_idx][way_reg].dirty          <= 1'b1;
                        write_ready_reg[grant_reg]                 <= 1'b1;
                    end else begin
                        read_data_reg[grant_reg]  <= cur_line.words[req_off];
                        read_ready_reg[grant_reg] <= 1'b1;
                    end
                    state_reg <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign consumer_read_ready  = read_ready_reg;
    assign consumer_write_ready = write_ready_reg;
    assign consumer_read_data   = read_data_reg;
    assign mem_read_valid       = mem_read_valid_reg;
    assign mem_read_address     = mem_read_address_reg;
    assign mem_write_valid      = mem_write_valid_reg;
    assign mem_write_address    = mem_write_address_reg;
    assign mem_write_data       = mem_write_data_reg;

endmodule

// File: tb/tb_dcache_wb_bank.sv
// Directed bench for dcache_wb_bank: a word memory responder logs every accepted beat,
// and consumer transactions are checked against hand-computed data, latency and traffic.
module tb_dcache_wb_bank;

    localparam int NC = 8;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic [NC-1:0]        consumer_read_valid = '0;
    logic [NC-1:0][7:0]   consumer_read_address = '0;
    logic [NC-1:0]        consumer_read_ready;
    logic [NC-1:0][7:0]   consumer_read_data;
    logic [NC-1:0]        consumer_write_valid = '0;
    logic [NC-1:0][7:0]   consumer_write_address = '0;
    logic [NC-1:0][7:0]   consumer_write_data = '0;
    logic [NC-1:0]        consumer_write_ready;
    logic                 mem_read_valid;
    logic [7:0]           mem_read_address;
    logic                 mem_read_ready = 1'b0;
    logic [7:0]           mem_read_data = '0;
    logic                 mem_write_valid;
    logic [7:0]           mem_write_address;
    logic [7:0]           mem_write_data;
    logic                 mem_write_ready = 1'b0;

    int          checks = 0;
    int          failures = 0;
    logic [7:0]  mem [256];
    logic [16:0] ev_q [$];          // {is_write, address, data} per accepted beat
    bit          stall_hi = 1'b0;   // withhold ready on odd-offset refill beats

    dcache_wb_bank dut (
        .clk                    (clk),
        .reset                  (reset),
        .consumer_read_valid    (consumer_read_valid),
        .consumer_read_address  (consumer_read_address),
        .consumer_read_ready    (consumer_read_ready),
        .consumer_read_data     (consumer_read_data),
        .consumer_write_valid   (consumer_write_valid),
        .consumer_write_address (consumer_write_address),
        .consumer_write_data    (consumer_write_data),
        .consumer_write_ready   (consumer_write_ready),
        .mem_read_valid         (mem_read_valid),
        .mem_read_address       (mem_read_address),
        .mem_read_ready         (mem_read_ready),
        .mem_read_data          (mem_read_data),
        .mem_write_valid        (mem_write_valid),
        .mem_write_address      (mem_write_address),
        .mem_write_data         (mem_write_data),
        .mem_write_ready        (mem_write_ready)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [16:0] get_ev(input int i);
        if (i < ev_q.size()) return ev_q[i];
        return 17'h1FFFF;
    endfunction

    task automatic check_ev(input string tag, input int i, input logic [16:0] exp);
        check_val(tag, {15'b0, get_ev(i)}, {15'b0, exp});
    endtask

    // One-beat memory: ready for one cycle per beat, beats must be separated by idle valid.
    always @(negedge clk) begin
        if (mem_read_ready) begin
            check_val("rd_gap", {31'b0, mem_read_valid}, 32'd0);
            mem_read_ready = 1'b0;
        end else if (mem_read_valid && !(stall_hi && mem_read_address[0])) begin
            mem_read_ready = 1'b1;
            mem_read_data  = mem[mem_read_address];
            ev_q.push_back({1'b0, mem_read_address, mem[mem_read_address]});
        end
        if (mem_write_ready) begin
            check_val("wr_gap", {31'b0, mem_write_valid}, 32'd0);
            mem_write_ready = 1'b0;
        end else if (mem_write_valid) begin
            mem_write_ready         = 1'b1;
            mem[mem_write_address]  = mem_write_data;
            ev_q.push_back({1'b1, mem_write_address, mem_write_data});
        end
    end

    task automatic wait_ready(input int c, input bit is_wr, input string tag, output int cyc);
        bit seen;
        seen = 1'b0;
        cyc  = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            cyc++;
            seen = is_wr ? consumer_write_ready[c] : consumer_read_ready[c];
        end
        check_val({tag, "_done"}, {31'b0, seen}, 32'd1);
    endtask

    task automatic do_read(input int c, input logic [7:0] addr, input logic [7:0] exp,
                           input string tag, input int exp_cyc);
        int cyc;
        consumer_read_address[c] = addr;
        consumer_read_valid[c]   = 1'b1;
        wait_ready(c, 1'b0, tag, cyc);
        check_val({tag, "_data"}, {24'b0, consumer_read_data[c]}, {24'b0, exp});
        if (exp_cyc != 0) check_val({tag, "_lat"}, cyc, exp_cyc);
        consumer_read_valid[c] = 1'b0;
        $display("read  c=%0d addr=0x%02h data=0x%02h cycles=%0d", c, addr, consumer_read_data[c], cyc);
        @(negedge clk);
        check_val({tag, "_pulse"}, {31'b0, consumer_read_ready[c]}, 32'd0);
    endtask

    task automatic do_write(input int c, input logic [7:0] addr, input logic [7:0] data,
                            input string tag, input int exp_cyc);
        int cyc;
        consumer_write_address[c] = addr;
        consumer_write_data[c]    = data;
        consumer_write_valid[c]   = 1'b1;
        wait_ready(c, 1'b1, tag, cyc);
        if (exp_cyc != 0) check_val({tag, "_lat"}, cyc, exp_cyc);
        consumer_write_valid[c] = 1'b0;
        $display("write c=%0d addr=0x%02h data=0x%02h cycles=%0d", c, addr, data, cyc);
        @(negedge clk);
        check_val({tag, "_pulse"}, {31'b0, consumer_write_ready[c]}, 32'd0);
    endtask

    task automatic two_reads(input int ca, input logic [7:0] aa, input logic [7:0] ea,
                             input int cb, input logic [7:0] ab, input logic [7:0] eb,
                             input int exp_first, input string tag);
        bit done_a;
        bit done_b;
        int first;
        done_a = 1'b0;
        done_b = 1'b0;
        first  = -1;
        consumer_read_address[ca] = aa;
        consumer_read_address[cb] = ab;
        consumer_read_valid[ca]   = 1'b1;
        consumer_read_valid[cb]   = 1'b1;
        for (int i = 0; i < 200 && !(done_a && done_b); i++) begin
            @(negedge clk);
            if (!done_a && consumer_read_ready[ca]) begin
                done_a = 1'b1;
                consumer_read_valid[ca] = 1'b0;
                if (first < 0) first = ca;
                check_val({tag, "_data_a"}, {24'b0, consumer_read_data[ca]}, {24'b0, ea});
                $display("read  c=%0d addr=0x%02h data=0x%02h", ca, aa, consumer_read_data[ca]);
            end
            if (!done_b && consumer_read_ready[cb]) begin
                done_b = 1'b1;
                consumer_read_valid[cb] = 1'b0;
                if (first < 0) first = cb;
                check_val({tag, "_data_b"}, {24'b0, consumer_read_data[cb]}, {24'b0, eb});
                $display("read  c=%0d addr=0x%02h data=0x%02h", cb, ab, consumer_read_data[cb]);
            end
        end
        check_val({tag, "_both"}, {30'b0, done_a, done_b}, 32'd3);
        check_val({tag, "_first"}, first, exp_first);
        @(negedge clk);
    endtask

    task automatic check_idle_outputs(input string tag);
        check_val({tag, "_ready"}, {16'b0, consumer_read_ready, consumer_write_ready}, 32'd0);
        check_val({tag, "_rdata_lo"}, consumer_read_data[3:0], 32'd0);
        check_val({tag, "_rdata_hi"}, consumer_read_data[7:4], 32'd0);
        check_val({tag, "_mem"}, {6'b0, mem_read_valid, mem_read_address, mem_write_valid,
                                  mem_write_address, mem_write_data}, 32'd0);
    endtask

    initial begin
        int m;
        bit seen;
        for (int i = 0; i < 256; i++) begin
            logic [7:0] a;
            a = i[7:0];
            mem[i] = {a[3:0], a[7:4]};
        end
        mem[8'h10] = 8'hAA;
        mem[8'h11] = 8'hBB;

        // Reset held for one rising edge.
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_idle_outputs("t1_rst");

        // Cold miss refills the block, then a hit on the other word.
        m = ev_q.size();
        do_read(0, 8'h10, 8'hAA, "t2_cold", 0);
        check_val("t2_cold_nev", ev_q.size() - m, 2);
        check_ev("t2_ev0", m,     {1'b0, 8'h10, 8'hAA});
        check_ev("t2_ev1", m + 1, {1'b0, 8'h11, 8'hBB});
        m = ev_q.size();
        do_read(0, 8'h11, 8'hBB, "t2_hit", 3);
        check_val("t2_hit_nev", ev_q.size() - m, 0);

        // Write hit dirties the line; filling set 0 forces its eviction.
        m = ev_q.size();
        do_write(1, 8'h11, 8'h55, "t3_wr", 3);
        check_val("t3_wr_nev", ev_q.size() - m, 0);
        do_read(1, 8'h20, 8'h02, "t3_r20", 0);
        do_read(1, 8'h40, 8'h04, "t3_r40", 0);
        do_read(1, 8'h60, 8'h06, "t3_r60", 0);
        m = ev_q.size();
        do_read(1, 8'h80, 8'h08, "t3_r80", 0);
        check_val("t3_evict_nev", ev_q.size() - m, 4);
        check_ev("t3_ev0", m,     {1'b1, 8'h10, 8'hAA});
        check_ev("t3_ev1", m + 1, {1'b1, 8'h11, 8'h55});
        check_ev("t3_ev2", m + 2, {1'b0, 8'h80, 8'h08});
        check_ev("t3_ev3", m + 3, {1'b0, 8'h81, 8'h18});

        // Round-robin: pointer sits at 2, then at 6 after serving 5.
        m = ev_q.size();
        two_reads(2, 8'h20, 8'h02, 5, 8'h41, 8'h14, 2, "t4_a");
        two_reads(2, 8'h60, 8'h06, 6, 8'h81, 8'h18, 6, "t4_b");
        check_val("t4_nev", ev_q.size() - m, 0);

        // Write miss allocates a clean victim with no memory write.
        m = ev_q.size();
        do_write(3, 8'h31, 8'h77, "t5_wr", 0);
        check_val("t5_nev", ev_q.size() - m, 2);
        check_ev("t5_ev0", m,     {1'b0, 8'h30, 8'h03});
        check_ev("t5_ev1", m + 1, {1'b0, 8'h31, 8'h13});
        do_read(3, 8'h31, 8'h77, "t5_rd", 3);
        check_val("t5_rd_nev", ev_q.size() - m, 2);

        // Reset while the second refill beat is outstanding.
        stall_hi = 1'b1;
        m = ev_q.size();
        consumer_read_address[4] = 8'hA0;
        consumer_read_valid[4]   = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            seen = mem_read_valid && (mem_read_address == 8'hA1);
        end
        check_val("t6_beat2", {31'b0, seen}, 32'd1);
        reset = 1'b1;
        consumer_read_valid[4] = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        check_idle_outputs("t6_rst");
        check_val("t6_partial_nev", ev_q.size() - m, 1);
        stall_hi = 1'b0;
        @(negedge clk);
        m = ev_q.size();
        do_read(4, 8'hA0, 8'h0A, "t6_rd", 0);
        check_val("t6_rd_nev", ev_q.size() - m, 2);
        check_ev("t6_ev0", m,     {1'b0, 8'hA0, 8'h0A});
        check_ev("t6_ev1", m + 1, {1'b0, 8'hA1, 8'h1A});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=running expected=finished");
        $fatal(1);
    end

endmodule
